// File: rtl/video_out_pkg.sv
// Shared types, aspect constants and colour helpers for the video output stage.
// Pure package: no logic, no latency, no flow control.
package video_out_pkg;

    typedef enum logic [1:0] {
        SL_OFF = 2'd0,
        SL_25  = 2'd1,
        SL_50  = 2'd2,
        SL_75  = 2'd3
    } sl_mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } pix_t;

    localparam logic [12:0] AR43_X  = 13'd4;
    localparam logic [12:0] AR43_Y  = 13'd3;
    localparam logic [12:0] AR169_X = 13'd16;
    localparam logic [12:0] AR169_Y = 13'd9;

    // v_msb holds the channel left-justified; its top 'bits' bits repeat down to bit 0.
    function automatic logic [7:0] expand8(input logic [7:0] v_msb, input int bits);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[7-i] = v_msb[7-(i%bits)];
        end
        return res;
    endfunction

    function automatic logic [7:0] dim8(input logic [7:0] v, input sl_mode_t mode);
        logic [7:0] res;
        case (mode)
            SL_25:   res = v - (v >> 2);
            SL_50:   res = v >> 1;
            SL_75:   res = v >> 2;
            default: res = v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/video_out_stage_if.sv
// Core-side colour/sync inputs and framework-side video outputs of the output stage.
// Plain wires; no latency or backpressure of its own.
interface video_out_stage_if #(
    parameter int COLOR_BITS = 1
);
    logic [COLOR_BITS-1:0] r_in;
    logic [COLOR_BITS-1:0] g_in;
    logic [COLOR_BITS-1:0] b_in;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  hblank_in;
    logic                  vblank_in;
    logic                  aspect_sel;
    logic [1:0]            scanline_sel;
    logic                  ce_pix;
    logic [7:0]            vga_r;
    logic [7:0]            vga_g;
    logic [7:0]            vga_b;
    logic                  vga_hs;
    logic                  vga_vs;
    logic                  vga_de;
    logic [12:0]           video_arx;
    logic [12:0]           video_ary;

    modport master (
        output r_in, g_in, b_in, hsync_in, vsync_in, hblank_in, vblank_in,
               aspect_sel, scanline_sel,
        input  ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
               video_arx, video_ary
    );

    modport slave (
        input  r_in, g_in, b_in, hsync_in, vsync_in, hblank_in, vblank_in,
               aspect_sel, scanline_sel,
        output ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
               video_arx, video_ary
    );

endinterface

// File: rtl/pix_ce_gen.sv
// Pixel clock enable: one-cycle registered pulse every CE_DIV clocks, first pulse CE_DIV clocks after reset.
// Free running; no backpressure.
module pix_ce_gen #(
    parameter int CE_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic ce_pix
);
    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce_q, ce_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        ce_d  = (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_pix = ce_q;

endmodule

// File: rtl/video_out_stage.sv
// Expands core RGB to 8 bits, aligns sync/DE, applies scanline dimming; settings switch only on vsync rise.
// Latency 2 ce_pix pulses for colour/sync/DE; advances only on ce_pix, no backpressure.
module video_out_stage
    import video_out_pkg::*;
#(
    parameter int COLOR_BITS = 1,
    parameter int CE_DIV     = 1
) (
    input  logic             clk,
    input  logic             reset,
    video_out_stage_if.slave vif
);
    logic     ce;
    pix_t     s1_q, s1_d, s2_q, s2_d;
    logic     hs_prev_q, hs_prev_d;
    logic     vs_prev_q, vs_prev_d;
    logic     parity_q, parity_d;
    logic     asp_q, asp_d;
    sl_mode_t sl_q, sl_d;
    logic     hs_rise, vs_rise;

    pix_ce_gen #(.CE_DIV(CE_DIV)) u_ce (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (ce)
    );

    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        parity_d  = parity_q;
        asp_d     = asp_q;
        sl_d      = sl_q;
        hs_rise   = vif.hsync_in & ~hs_prev_q;
        vs_rise   = vif.vsync_in & ~vs_prev_q;
        if (ce) begin
            hs_prev_d = vif.hsync_in;
            vs_prev_d = vif.vsync_in;
            // Frame start wins over a coincident line start.
            parity_d  = vs_rise ? 1'b0 : (parity_q ^ hs_rise);
            if (vs_rise) begin
                sl_d  = sl_mode_t'(vif.scanline_sel);
                asp_d = vif.aspect_sel;
            end
            s1_d.r  = expand8(8'(vif.r_in) << (8 - COLOR_BITS), COLOR_BITS);
            s1_d.g  = expand8(8'(vif.g_in) << (8 - COLOR_BITS), COLOR_BITS);
            s1_d.b  = expand8(8'(vif.b_in) << (8 - COLOR_BITS), COLOR_BITS);
            s1_d.hs = vif.hsync_in;
            s1_d.vs = vif.vsync_in;
            s1_d.de = ~(vif.hblank_in | vif.vblank_in);
            // parity_q/sl_q already reflect the line and frame of the pixel now in stage 1.
            s2_d    = s1_q;
            s2_d.r  = s1_q.de ? dim8(s1_q.r, parity_q ? sl_q : SL_OFF) : 8'd0;
            s2_d.g  = s1_q.de ? dim8(s1_q.g, parity_q ? sl_q : SL_OFF) : 8'd0;
            s2_d.b  = s1_q.de ? dim8(s1_q.b, parity_q ? sl_q : SL_OFF) : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            parity_q  <= 1'b0;
            sl_q      <= sl_mode_t'(vif.scanline_sel);
            asp_q     <= vif.aspect_sel;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            parity_q  <= parity_d;
            sl_q      <= sl_d;
            asp_q     <= asp_d;
        end
    end

    assign vif.ce_pix    = ce;
    assign vif.vga_r     = s2_q.r;
    assign vif.vga_g     = s2_q.g;
    assign vif.vga_b     = s2_q.b;
    assign vif.vga_hs    = s2_q.hs;
    assign vif.vga_vs    = s2_q.vs;
    assign vif.vga_de    = s2_q.de;
    assign vif.video_arx = asp_q ? AR169_X : AR43_X;
    assign vif.video_ary = asp_q ? AR169_Y : AR43_Y;

endmodule

// File: tb/tb_video_out_stage.sv
// Bench for video_out_stage: a 3-bit/CE_DIV=1 instance against a behavioural model plus tables and
// hand sequences, and a 1-bit/CE_DIV=4 instance for enable timing and sample-hold behaviour.
module tb_video_out_stage;

    localparam int CB_A = 3;
    localparam int CE_A = 1;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    video_out_stage_if #(.COLOR_BITS(CB_A)) vif_a ();
    video_out_stage_if #(.COLOR_BITS(1))    vif_b ();

    video_out_stage #(.COLOR_BITS(CB_A), .CE_DIV(CE_A)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vif   (vif_a)
    );

    video_out_stage #(.COLOR_BITS(1), .CE_DIV(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vif   (vif_b)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int r, g, b, hs, vs, de;
    } px_t;

    typedef struct {
        int r, g, b, hb, vb;
        int er, eg, eb, ede;
    } vec_t;

    // Behavioural model state for instance A
    bit  m_hs_prev, m_vs_prev, m_par, m_asp, m_ce;
    int  m_mode, m_k;
    px_t m_pend, m_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int expand_ref(input int v, input int bits);
        int acc = 0;
        int n = 0;
        while (n < 8) begin
            acc = (acc << bits) | v;
            n += bits;
        end
        return (acc >> (n - 8)) & 255;
    endfunction

    function automatic int dim_ref(input int v, input int mode);
        case (mode)
            1:       return v - v / 4;
            2:       return v / 2;
            3:       return v / 4;
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        int hs, vs, de, eff;
        bit hr, vr;
        if (rst_a) begin
            m_hs_prev = 0; m_vs_prev = 0; m_par = 0;
            m_mode = int'(vif_a.scanline_sel);
            m_asp  = vif_a.aspect_sel;
            m_pend = '{default: 0};
            m_out  = '{default: 0};
            m_k = 0; m_ce = 0;
        end else begin
            if (m_ce) begin
                m_out = m_pend;
                hs = int'(vif_a.hsync_in);
                vs = int'(vif_a.vsync_in);
                hr = (hs == 1) && !m_hs_prev;
                vr = (vs == 1) && !m_vs_prev;
                m_hs_prev = hs[0];
                m_vs_prev = vs[0];
                if (vr) m_par = 0;
                else if (hr) m_par = !m_par;
                if (vr) begin
                    m_mode = int'(vif_a.scanline_sel);
                    m_asp  = vif_a.aspect_sel;
                end
                de  = (vif_a.hblank_in || vif_a.vblank_in) ? 0 : 1;
                eff = m_par ? m_mode : 0;
                m_pend.r  = de ? dim_ref(expand_ref(int'(vif_a.r_in), CB_A), eff) : 0;
                m_pend.g  = de ? dim_ref(expand_ref(int'(vif_a.g_in), CB_A), eff) : 0;
                m_pend.b  = de ? dim_ref(expand_ref(int'(vif_a.b_in), CB_A), eff) : 0;
                m_pend.hs = hs;
                m_pend.vs = vs;
                m_pend.de = de;
            end
            m_k++;
            m_ce = (m_k % CE_A) == 0;
        end
    endtask

    task automatic step_a(input int r, input int g, input int b, input int hs, input int vs,
                          input int hb, input int vb);
        vif_a.r_in      = CB_A'(r);
        vif_a.g_in      = CB_A'(g);
        vif_a.b_in      = CB_A'(b);
        vif_a.hsync_in  = (hs != 0);
        vif_a.vsync_in  = (vs != 0);
        vif_a.hblank_in = (hb != 0);
        vif_a.vblank_in = (vb != 0);
        @(posedge clk);
        model_edge();
        #1;
        chk("a_ce", int'(vif_a.ce_pix), int'(m_ce));
        chk("a_rgb", int'({vif_a.vga_r, vif_a.vga_g, vif_a.vga_b}),
            (m_out.r << 16) | (m_out.g << 8) | m_out.b);
        chk("a_sync", int'({vif_a.vga_hs, vif_a.vga_vs, vif_a.vga_de}),
            (m_out.hs << 2) | (m_out.vs << 1) | m_out.de);
        chk("a_aspect", int'({vif_a.video_arx, vif_a.video_ary}),
            m_asp ? ((16 << 13) | 9) : ((4 << 13) | 3));
    endtask

    function automatic int rgb_a();
        return int'({vif_a.vga_r, vif_a.vga_g, vif_a.vga_b});
    endfunction

    function automatic int ar_a();
        return int'({vif_a.video_arx, vif_a.video_ary});
    endfunction

    task automatic set_b(input int r, input int g, input int b, input int hs, input int hb);
        vif_b.r_in      = 1'(r);
        vif_b.g_in      = 1'(g);
        vif_b.b_in      = 1'(b);
        vif_b.hsync_in  = (hs != 0);
        vif_b.vsync_in  = 1'b0;
        vif_b.hblank_in = (hb != 0);
        vif_b.vblank_in = 1'b0;
    endtask

    vec_t tv[8];

    initial begin
        tv[0] = '{r:5, g:7, b:1, hb:0, vb:0, er:'hB6, eg:'hFF, eb:'h24, ede:1};
        tv[1] = '{r:0, g:2, b:4, hb:0, vb:0, er:'h00, eg:'h49, eb:'h92, ede:1};
        tv[2] = '{r:6, g:3, b:5, hb:0, vb:0, er:'hDB, eg:'h6D, eb:'hB6, ede:1};
        tv[3] = '{r:7, g:7, b:7, hb:1, vb:0, er:'h00, eg:'h00, eb:'h00, ede:0};
        tv[4] = '{r:7, g:7, b:7, hb:0, vb:1, er:'h00, eg:'h00, eb:'h00, ede:0};
        tv[5] = '{r:7, g:0, b:7, hb:0, vb:0, er:'hFF, eg:'h00, eb:'hFF, ede:1};
        tv[6] = '{r:3, g:6, b:2, hb:1, vb:1, er:'h00, eg:'h00, eb:'h00, ede:0};
        tv[7] = '{r:1, g:1, b:1, hb:0, vb:0, er:'h24, eg:'h24, eb:'h24, ede:1};

        rst_a = 1'b1;
        rst_b = 1'b1;
        vif_a.aspect_sel   = 1'b1;
        vif_a.scanline_sel = 2'd0;
        vif_b.aspect_sel   = 1'b0;
        vif_b.scanline_sel = 2'd0;
        set_b(0, 0, 0, 0, 0);

        // Reset: outputs cleared, aspect follows the selector directly
        repeat (3) step_a(7, 7, 7, 1, 1, 0, 0);
        chk("rst_rgb", rgb_a(), 0);
        chk("rst_ar_169", ar_a(), (16 << 13) | 9);
        vif_a.aspect_sel = 1'b0;
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("rst_ar_43", ar_a(), (4 << 13) | 3);
        rst_a = 1'b0;

        // Table: expansion and blanking, two-cycle latency
        step_a(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step_a(tv[i].r, tv[i].g, tv[i].b, 0, 0, tv[i].hb, tv[i].vb);
            else       step_a(0, 0, 0, 0, 0, 0, 0);
            if (i >= 1) begin
                chk($sformatf("vec%0d_rgb", i - 1), rgb_a(),
                    (tv[i-1].er << 16) | (tv[i-1].eg << 8) | tv[i-1].eb);
                chk($sformatf("vec%0d_de", i - 1), int'(vif_a.vga_de), tv[i-1].ede);
            end
        end

        // 50% scanlines, then coincident hsync/vsync rise
        vif_a.scanline_sel = 2'd2;
        step_a(7, 7, 7, 0, 1, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("sl50_even", int'(vif_a.vga_r), 'hFF);
        step_a(7, 7, 7, 1, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("sl50_odd", int'(vif_a.vga_r), 'h7F);
        step_a(7, 7, 7, 1, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("sl50_even2", int'(vif_a.vga_r), 'hFF);
        step_a(7, 7, 7, 1, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("sl50_odd2", int'(vif_a.vga_r), 'h7F);
        step_a(7, 7, 7, 1, 1, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("both_rise_par0", int'(vif_a.vga_r), 'hFF);

        // Mid-frame settings change waits for the next vsync rise
        vif_a.aspect_sel   = 1'b0;
        vif_a.scanline_sel = 2'd0;
        step_a(7, 7, 7, 0, 1, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        vif_a.aspect_sel   = 1'b1;
        vif_a.scanline_sel = 2'd3;
        step_a(7, 7, 7, 1, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("ar_hold", ar_a(), (4 << 13) | 3);
        chk("sl_hold", int'(vif_a.vga_r), 'hFF);
        step_a(7, 7, 7, 0, 1, 0, 0);
        chk("ar_new", ar_a(), (16 << 13) | 9);
        step_a(7, 7, 7, 0, 0, 0, 0);
        step_a(7, 7, 7, 1, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("sl75_odd", int'(vif_a.vga_r), 'h3F);

        // Reset in the middle of an odd line
        vif_a.aspect_sel = 1'b0;
        rst_a = 1'b1;
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("rst_mid_rgb", rgb_a(), 0);
        chk("rst_mid_de", int'(vif_a.vga_de), 0);
        chk("rst_mid_ar", ar_a(), (4 << 13) | 3);
        rst_a = 1'b0;
        step_a(7, 7, 7, 0, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        step_a(7, 7, 7, 0, 0, 0, 0);
        chk("rst_par0", rgb_a(), 'hFFFFFF);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) vif_a.aspect_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) vif_a.scanline_sel = 2'($urandom_range(0, 3));
            rst_a = ($urandom_range(0, 99) == 0);
            step_a(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 40) == 0),
                   int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 9) == 0));
        end
        rst_a = 1'b0;

        // Instance B: CE_DIV=4 pulse timing, sample-hold, 1-bit expansion
        repeat (2) @(posedge clk);
        #1;
        chk("b_rst_ce", int'(vif_b.ce_pix), 0);
        chk("b_rst_rgb", int'({vif_b.vga_r, vif_b.vga_g, vif_b.vga_b}), 0);
        rst_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b_ce_k%0d", k), int'(vif_b.ce_pix), int'((k % 4) == 0));
            if (k == 1) set_b(1, 0, 1, 1, 0);
            if (k == 5) set_b(0, 1, 0, 0, 0);
            if (k == 8) begin
                chk("b_early_rgb", int'({vif_b.vga_r, vif_b.vga_g, vif_b.vga_b}), 0);
                chk("b_early_de", int'(vif_b.vga_de), 0);
                set_b(1, 1, 1, 0, 1);
            end
            if (k >= 9 && k <= 12) begin
                chk($sformatf("b_hold_rgb_k%0d", k),
                    int'({vif_b.vga_r, vif_b.vga_g, vif_b.vga_b}), 'hFF00FF);
                chk($sformatf("b_hold_sync_k%0d", k),
                    int'({vif_b.vga_hs, vif_b.vga_vs, vif_b.vga_de}), 5);
            end
            if (k == 13) begin
                chk("b_next_rgb", int'({vif_b.vga_r, vif_b.vga_g, vif_b.vga_b}), 0);
                chk("b_next_sync", int'({vif_b.vga_hs, vif_b.vga_vs, vif_b.vga_de}), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
